// File: rtl/alu_addsub_serial_if.sv
// Request/response bundle for the serial XM23 add/subtract unit.
// The master drives the request and the result acknowledge; the slave is the ALU.
`timescale 1ns/1ps
interface alu_addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             byte_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             result_we;
    logic [15:0]      psw_out;
    logic [15:0]      psw_msk;
    logic             op_err;
    logic             busy;

    modport master (
        output in_valid, op, byte_mode, a, b, c_in, out_ready,
        input  in_ready, out_valid, result, result_we, psw_out, psw_msk, op_err, busy
    );

    modport slave (
        input  in_valid, op, byte_mode, a, b, c_in, out_ready,
        output in_ready, out_valid, result, result_we, psw_out, psw_msk, op_err, busy
    );
endinterface

// File: rtl/alu_addsub_serial.sv
// Digit-serial ADD/ADDC/SUB/SUBC/CMP unit producing XM23 PSW flags and update mask.
// Define ALU_ADDSUB_DADD_EN to add the BCD DADD op (requires SLICE == 4).
`timescale 1ns/1ps
module alu_addsub_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input logic                clk,
    input logic                rst,
    alu_addsub_serial_if.slave bus
);
    localparam int NW    = WIDTH / SLICE;
    localparam int NB    = 8 / SLICE;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDC = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SUBC = 3'b011;
    localparam logic [2:0] OP_CMP  = 3'b100;
`ifdef ALU_ADDSUB_DADD_EN
    localparam logic [2:0] OP_DADD = 3'b101;
`endif

    generate
        if ((WIDTH % 8 != 0) || (WIDTH % SLICE != 0) || (8 % SLICE != 0)) begin : g_bad_geom
            $error("alu_addsub_serial: WIDTH must be a multiple of 8 and SLICE, SLICE must divide 8");
        end
`ifdef ALU_ADDSUB_DADD_EN
        if (SLICE != 4) begin : g_bad_dadd
            $error("alu_addsub_serial: DADD requires SLICE == 4");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               byte_q, byte_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // b' : already inverted for subtracts
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [15:0]        psw_q, psw_d;
    logic [15:0]        msk_q, msk_d;
    logic               we_q, we_d;
    logic               err_q, err_d;

    logic               accept;
    logic [SLICE-1:0]   a_s, b_s;
    logic [SLICE:0]     sum_s;
    logic               c_next;
    logic [CNT_W-1:0]   last_idx;
    logic               legal;
    logic               is_dadd;
    logic               a_msb, b_msb, r_msb, flag_z, flag_v;
`ifdef ALU_ADDSUB_DADD_EN
    logic [SLICE+1:0]   dig_s;
`endif

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
    assign bus.psw_out   = psw_q;
    assign bus.psw_msk   = msk_q;
    assign bus.result_we = we_q;
    assign bus.op_err    = err_q;

    assign last_idx = byte_q ? CNT_W'(NB - 1) : CNT_W'(NW - 1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        byte_d   = byte_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        psw_d    = psw_q;
        msk_d    = msk_q;
        we_d     = we_q;
        err_d    = err_q;
        accept   = 1'b0;
        a_s      = a_q[cnt_q*SLICE +: SLICE];
        b_s      = b_q[cnt_q*SLICE +: SLICE];
        sum_s    = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        c_next   = sum_s[SLICE];
        is_dadd  = 1'b0;
`ifdef ALU_ADDSUB_DADD_EN
        is_dadd  = (op_q == OP_DADD);
        dig_s    = {2'b00, a_s} + {2'b00, b_s} + {{(SLICE+1){1'b0}}, carry_q};
        if (is_dadd) begin
            if (dig_s > 9) begin
                dig_s  = dig_s + 6;
                c_next = 1'b1;
            end else begin
                c_next = 1'b0;
            end
            sum_s = {c_next, dig_s[SLICE-1:0]};
        end
`endif
        legal    = (op_q <= OP_CMP) || is_dadd;
        a_msb    = byte_q ? a_q[7] : a_q[WIDTH-1];
        b_msb    = byte_q ? b_q[7] : b_q[WIDTH-1];
        r_msb    = 1'b0;
        flag_z   = 1'b0;
        flag_v   = 1'b0;

        case (state_q)
            IDLE: accept = bus.in_valid;
            RUN: begin
                acc_d[cnt_q*SLICE +: SLICE] = sum_s[SLICE-1:0];
                carry_d = c_next;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == last_idx) begin
                    state_d  = DONE;
                    r_msb    = byte_q ? acc_d[7] : acc_d[WIDTH-1];
                    flag_z   = byte_q ? (acc_d[7:0] == 8'h00) : (acc_d == '0);
                    flag_v   = !is_dadd && (a_msb == b_msb) && (r_msb != a_msb);
                    result_d = acc_d;
                    psw_d    = {11'd0, flag_v, 1'b0, r_msb, flag_z, c_next};
                    msk_d    = !legal ? 16'h0000 : (is_dadd ? 16'h0007 : 16'h0017);
                    we_d     = legal && (op_q != OP_CMP);
                    err_d    = !legal;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    accept  = bus.in_valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Illegal ops fall through with b' = b and carry 0, i.e. they compute as ADD.
        if (accept) begin
            state_d = RUN;
            op_d    = bus.op;
            byte_d  = bus.byte_mode;
            a_d     = bus.a;
            acc_d   = bus.a;
            b_d     = bus.b;
            carry_d = 1'b0;
            cnt_d   = '0;
            case (bus.op)
                OP_ADD:  carry_d = 1'b0;
                OP_ADDC: carry_d = bus.c_in;
                OP_SUB, OP_CMP: begin
                    b_d     = ~bus.b;
                    carry_d = 1'b1;
                end
                OP_SUBC: begin
                    b_d     = ~bus.b;
                    carry_d = bus.c_in;
                end
`ifdef ALU_ADDSUB_DADD_EN
                OP_DADD: carry_d = bus.c_in;
`endif
                default: carry_d = 1'b0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            byte_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            psw_q    <= '0;
            msk_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            byte_q   <= byte_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            psw_q    <= psw_d;
            msk_q    <= msk_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end
endmodule
